// File: rtl/seq_pkg.sv
// Shared definitions for the exhaustive vector sequencer: FSM state encoding and defaults.
package seq_pkg;

  localparam int STATE_W        = 2;
  localparam int DEFAULT_SETTLE = 20;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds at zero; expired flags the zero count.
module settle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps every N_IN-bit vector into a combinational CUT and checks its truth table.
// Optional MISMATCH_LOG_EN adds first_err_vec/first_err_valid reporting.
module exhaustive_vector_sequencer
  import seq_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter int                 SETTLE   = DEFAULT_SETTLE,
  parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   observed,
  output logic [N_IN:0]        err_count
`ifdef MISMATCH_LOG_EN
  ,
  output logic [N_IN-1:0]      first_err_vec,
  output logic                 first_err_valid
`endif
);

  localparam int              TW     = $clog2(SETTLE + 1);
  localparam logic [TW-1:0]   RELOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("exhaustive_vector_sequencer: SETTLE must be >= 1");
    end
  endgenerate

  state_t state_q, state_d;
  logic   accept, sample, load, expired, mismatch, last_vec;

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (RELOAD),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign last_vec = (vec_out == LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          load    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        sample = 1'b1;
        if (last_vec) begin
          state_d = DONE;
        end else begin
          load    = 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == DRIVE) || (state_q == SAMPLE);

  // Case-inequality so an X or Z response is never mistaken for a match.
  assign mismatch = (resp !== EXPECTED[vec_out]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out   <= '0;
      observed  <= '0;
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (accept) begin
      vec_out   <= '0;
      observed  <= '0;
      err_count <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (sample) begin
      observed[vec_out] <= resp;
      if (mismatch) err_count <= err_count + 1'b1;
      if (last_vec) begin
        done <= 1'b1;
        pass <= (err_count == '0) && !mismatch;
      end else begin
        vec_out <= vec_out + 1'b1;
      end
    end
  end

`ifdef MISMATCH_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (accept) begin
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (sample && mismatch && !first_err_valid) begin
      first_err_vec   <= vec_out;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Bench for exhaustive_vector_sequencer: sweep-position reference model plus directed checks.
module tb_exhaustive_vector_sequencer;

  localparam int         N_IN     = 3;
  localparam int         SETTLE   = 2;
  localparam int         NV       = 8;
  localparam int         P        = SETTLE + 1;
  localparam logic [7:0] EXPECTED = 8'h96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tt = 8'h96;
  logic       resp;
  logic [2:0] vec_out;
  logic       busy, done, pass;
  logic [7:0] observed;
  logic [3:0] err_count;
`ifdef MISMATCH_LOG_EN
  logic [2:0] first_err_vec;
  logic       first_err_valid;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  exhaustive_vector_sequencer #(
    .N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(EXPECTED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .resp(resp),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .observed(observed), .err_count(err_count)
`ifdef MISMATCH_LOG_EN
    , .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
`endif
  );

  // The CUT is a truth table looked up by the applied vector.
  assign resp = tt[vec_out];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a sweep is P edges per vector; m_k counts edges since the accepted start.
  int         m_k = 0;
  bit         m_busy = 0, m_done = 0, m_fv = 0;
  logic [7:0] m_obs = '0;
  int         m_err = 0, m_fvec = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_busy <= 0; m_done <= 0; m_obs <= '0; m_err <= 0; m_fv <= 0; m_fvec <= 0;
    end else if (!m_busy && start) begin
      m_k <= 0; m_busy <= 1; m_done <= 0; m_obs <= '0; m_err <= 0; m_fv <= 0; m_fvec <= 0;
    end else if (m_busy) begin
      m_k <= m_k + 1;
      if ((m_k + 1) % P == 0) begin
        m_obs[(m_k + 1) / P - 1] <= tt[(m_k + 1) / P - 1];
        if (tt[(m_k + 1) / P - 1] != EXPECTED[(m_k + 1) / P - 1]) begin
          m_err <= m_err + 1;
          if (!m_fv) begin m_fv <= 1; m_fvec <= (m_k + 1) / P - 1; end
        end
        if ((m_k + 1) / P == NV) begin m_busy <= 0; m_done <= 1; end
      end
    end
  end

  function automatic int exp_vec();
    if (m_busy) return m_k / P;
    if (m_done) return NV - 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    check("m_vec_out",   {29'd0, vec_out}, exp_vec());
    check("m_busy",      {31'd0, busy},    {31'd0, m_busy});
    check("m_done",      {31'd0, done},    {31'd0, m_done});
    check("m_pass",      {31'd0, pass},    {31'd0, (m_done && m_err == 0)});
    check("m_observed",  {24'd0, observed}, {24'd0, m_obs});
    check("m_err_count", {28'd0, err_count}, m_err);
`ifdef MISMATCH_LOG_EN
    check("m_first_valid", {31'd0, first_err_valid}, {31'd0, m_fv});
    check("m_first_vec",   {29'd0, first_err_vec},   m_fvec);
`endif
  end

  task automatic run_sweep(output int lat);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
    end
    check("sweep_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int i;
    for (i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (vec_out == v && busy) break;
    end
    check("wait_vec_reached", {29'd0, vec_out}, {29'd0, v});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("wait_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check("reset_vec",  {29'd0, vec_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err",  {28'd0, err_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Parity CUT matches the golden table exactly.
    tt = 8'h96;
    run_sweep(lat);
    check("t1_latency",  lat, 32'd25);
    check("t1_observed", {24'd0, observed}, 32'h96);
    check("t1_err",      {28'd0, err_count}, 32'd0);
    check("t1_pass",     {31'd0, pass}, 32'd1);

    // Stuck-at-0 output.
    tt = 8'h00;
    run_sweep(lat);
    check("t2_observed", {24'd0, observed}, 32'h00);
    check("t2_err",      {28'd0, err_count}, 32'd4);
    check("t2_pass",     {31'd0, pass}, 32'd0);

    // Restart from DONE clears results immediately.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t5_done",     {31'd0, done}, 32'd0);
    check("t5_pass",     {31'd0, pass}, 32'd0);
    check("t5_observed", {24'd0, observed}, 32'd0);
    check("t5_err",      {28'd0, err_count}, 32'd0);
    check("t5_vec",      {29'd0, vec_out}, 32'd0);
    check("t5_busy",     {31'd0, busy}, 32'd1);
    wait_done();

    // Start while busy is ignored.
    tt = 8'h3c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd3);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t3_vec_held", {29'd0, vec_out}, 32'd3);
    check("t3_busy",     {31'd0, busy}, 32'd1);
    wait_done();
    check("t3_err",      {28'd0, err_count}, 32'd4);
    check("t3_observed", {24'd0, observed}, 32'h3c);

    // Asynchronous reset mid-sweep.
    tt = 8'h96;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd4);
    #2 rst = 1'b1;
    #1;
    check("t4_vec",      {29'd0, vec_out}, 32'd0);
    check("t4_busy",     {31'd0, busy}, 32'd0);
    check("t4_done",     {31'd0, done}, 32'd0);
    check("t4_observed", {24'd0, observed}, 32'd0);
    check("t4_err",      {28'd0, err_count}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_sweep(lat);
    check("t4_rerun_latency", lat, 32'd25);
    check("t4_rerun_pass",    {31'd0, pass}, 32'd1);

    // Two injected faults at vec 5 and vec 6.
    tt = 8'h96 ^ 8'h60;
    run_sweep(lat);
    check("t6_err",  {28'd0, err_count}, 32'd2);
    check("t6_pass", {31'd0, pass}, 32'd0);
`ifdef MISMATCH_LOG_EN
    check("t6_first_vec",   {29'd0, first_err_vec}, 32'd5);
    check("t6_first_valid", {31'd0, first_err_valid}, 32'd1);
`endif

    // Random truth tables, checked by the model every cycle.
    for (int s = 0; s < 8; s++) begin
      tt = 8'($urandom);
      run_sweep(lat);
      check("rand_observed", {24'd0, observed}, {24'd0, tt});
      check("rand_err",      {28'd0, err_count}, $countones(tt ^ EXPECTED));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
